// File: rtl/frame_bank_scheduler_pkg.sv
// Shared types for the LED frame bank scheduler and its RAM clients.
// Bank ids, scheduler states and the free-bank picker.
package led_pkg;
  localparam int NBANKS = 3;
  localparam int CDEPTH = 8;
  localparam int PIX_W  = 3 * CDEPTH;

  typedef logic [1:0] bank_t;

  typedef enum logic {
    CLEAR,
    RUN
  } sched_state_t;

  // Lowest bank not displayed and not holding the ready frame
  function automatic bank_t free_bank(
    bank_t d,
    logic  rv,
    bank_t r
  );
    free_bank = 2'd0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (bank_t'(i) != d && !(rv && bank_t'(i) == r))
        free_bank = bank_t'(i);
    end
  endfunction
endpackage

// File: rtl/frame_bank_scheduler_if.sv
// Producer, consumer and clear-port signals of the frame bank scheduler.
// master = producer/consumer side, slave = scheduler.
import led_pkg::*;

interface frame_bank_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic              wr_begin;
  logic              wr_commit;
  logic              wr_abort;
  logic              wr_busy;
  bank_t             wr_bank;
  logic              wr_ready;
  logic              disp_req;
  logic              disp_ack;
  bank_t             disp_bank;
  logic              disp_new;
  logic              clr_we;
  bank_t             clr_bank;
  logic [ADDR_W-1:0] clr_addr;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output wr_begin, wr_commit, wr_abort, disp_req,
    input  wr_busy, wr_bank, wr_ready,
    input  disp_ack, disp_bank, disp_new,
    input  clr_we, clr_bank, clr_addr, drop_cnt
  );

  modport slave (
    input  wr_begin, wr_commit, wr_abort, disp_req,
    output wr_busy, wr_bank, wr_ready,
    output disp_ack, disp_bank, disp_new,
    output clr_we, clr_bank, clr_addr, drop_cnt
  );
endinterface

// File: rtl/frame_bank_scheduler_clear_sequencer.sv
// Walks every (bank, addr) pair once for the post-reset zero fill.
// done_o marks the final write at bank 2, addr all-ones.
import led_pkg::*;

module clear_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  output bank_t             bank_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);
  bank_t             bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign done_o = en_i && bank_q == 2'd2 && &addr_q;
  assign bank_o = bank_q;
  assign addr_o = addr_q;

  always_comb begin
    bank_d = bank_q;
    addr_d = addr_q;
    if (done_o) begin
      bank_d = 2'd0;
      addr_d = '0;
    end else if (en_i) begin
      addr_d = addr_q + 1'b1;
      if (&addr_q) bank_d = bank_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bank_q <= 2'd0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer role bookkeeping between frame producer and scan-out.
// Zero-fills all banks after reset, then runs the D/R/W rotation.
import led_pkg::*;

module frame_bank_scheduler #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  frame_bank_scheduler_if.slave  bus
);
  sched_state_t     state_q, state_d;
  bank_t            d_q, d_d;
  bank_t            r_q, r_d;
  bank_t            w_q, w_d;
  logic             rv_q, rv_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             new_q, new_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             clr_en;
  logic             clr_done;
  logic             cm;
  logic             ab;

  assign clr_en = state_q == CLEAR;

  clear_sequencer #(.ADDR_W(ADDR_W)) u_clr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (clr_en),
    .bank_o (bus.clr_bank),
    .addr_o (bus.clr_addr),
    .done_o (clr_done)
  );

  assign cm = bus.wr_commit && busy_q;
  assign ab = bus.wr_abort && busy_q && !bus.wr_commit;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    r_d     = r_q;
    w_d     = w_q;
    rv_d    = rv_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    new_d   = 1'b0;
    pend_d  = pend_q;
    drop_d  = drop_q;
    unique case (state_q)
      CLEAR: begin
        pend_d = pend_q | bus.disp_req;
        if (clr_done) begin
          state_d = RUN;
          ack_d   = pend_q | bus.disp_req;
          pend_d  = 1'b0;
        end
      end
      RUN: begin
        ack_d = bus.disp_req;
        // A same-cycle commit bypasses R straight into D
        if (bus.disp_req) begin
          if (cm) begin
            d_d   = w_q;
            rv_d  = 1'b0;
            new_d = 1'b1;
          end else if (rv_q) begin
            d_d   = r_q;
            rv_d  = 1'b0;
            new_d = 1'b1;
          end
        end else if (cm) begin
          r_d  = w_q;
          rv_d = 1'b1;
        end
        if (cm && rv_q && !(&drop_q)) drop_d = drop_q + 1'b1;
        if (cm || ab) begin
          busy_d = 1'b0;
        end else if (bus.wr_begin && !busy_q) begin
          busy_d = 1'b1;
          w_d    = free_bank(d_d, rv_d, r_d);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CLEAR;
      d_q     <= 2'd0;
      r_q     <= 2'd0;
      w_q     <= 2'd0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      new_q   <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      r_q     <= r_d;
      w_q     <= w_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      new_q   <= new_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.clr_we    = clr_en && reset;
  assign bus.wr_busy   = busy_q;
  assign bus.wr_bank   = w_q;
  assign bus.wr_ready  = state_q == RUN && !busy_q;
  assign bus.disp_ack  = ack_q;
  assign bus.disp_bank = d_q;
  assign bus.disp_new  = new_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed and random stimulus for frame_bank_scheduler against a role model.
// Small banks (ADDR_W=2) and a 4-bit drop counter keep wrap/saturation reachable.
module tb_frame_bank_scheduler;
  localparam int AW = 2;
  localparam int CW = 4;
  localparam int NCLR = 3 * (1 << AW);

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  frame_bank_scheduler_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  frame_bank_scheduler #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bank roles as plain integers
  bit m_run, m_rv, m_busy, m_ack, m_new, m_pend;
  int m_D, m_R, m_W, m_drop, m_clr;

  task automatic model_step();
    bit cm, ab, found;
    if (!reset) begin
      m_run = 0; m_rv = 0; m_busy = 0; m_ack = 0; m_new = 0;
      m_pend = 0; m_D = 0; m_R = 0; m_W = 0; m_drop = 0; m_clr = 0;
    end else if (!m_run) begin
      m_ack = 0;
      m_new = 0;
      if (bus.disp_req) m_pend = 1;
      m_clr++;
      if (m_clr == NCLR) begin
        m_run = 1;
        m_clr = 0;
        m_ack = m_pend;
        m_pend = 0;
      end
    end else begin
      cm = bus.wr_commit && m_busy;
      ab = bus.wr_abort && m_busy && !bus.wr_commit;
      m_ack = bus.disp_req;
      m_new = 0;
      if (cm && m_rv && m_drop != (1 << CW) - 1) m_drop++;
      if (bus.disp_req) begin
        if (cm) begin
          m_D = m_W; m_rv = 0; m_new = 1;
        end else if (m_rv) begin
          m_D = m_R; m_rv = 0; m_new = 1;
        end
      end else if (cm) begin
        m_R = m_W; m_rv = 1;
      end
      if (cm || ab) begin
        m_busy = 0;
      end else if (bus.wr_begin && !m_busy) begin
        found = 0;
        for (int b = 0; b < 3; b++) begin
          if (!found && b != m_D && !(m_rv && b == m_R)) begin
            m_W = b;
            found = 1;
          end
        end
        m_busy = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("clr_we", int'(bus.clr_we), int'(!m_run && reset));
    chk("clr_bank", int'(bus.clr_bank), m_clr / (1 << AW));
    chk("clr_addr", int'(bus.clr_addr), m_clr % (1 << AW));
    chk("wr_busy", int'(bus.wr_busy), int'(m_busy));
    chk("wr_bank", int'(bus.wr_bank), m_W);
    chk("wr_ready", int'(bus.wr_ready), int'(m_run && !m_busy));
    chk("disp_ack", int'(bus.disp_ack), int'(m_ack));
    chk("disp_bank", int'(bus.disp_bank), m_D);
    chk("disp_new", int'(bus.disp_new), int'(m_new));
    chk("drop_cnt", int'(bus.drop_cnt), m_drop);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input bit b, input bit c, input bit a, input bit r);
    bus.wr_begin = b;
    bus.wr_commit = c;
    bus.wr_abort = a;
    bus.disp_req = r;
  endtask

  task automatic pulse(input bit b, input bit c, input bit a, input bit r);
    drive(b, c, a, r);
    cycle();
    drive(0, 0, 0, 0);
  endtask

  task automatic do_reset_and_clear();
    reset = 1'b0;
    cycle();
    cycle();
    chk("rst_ready", int'(bus.wr_ready), 0);
    chk("rst_clr_we", int'(bus.clr_we), 0);
    chk("rst_drop", int'(bus.drop_cnt), 0);
    chk("rst_busy", int'(bus.wr_busy), 0);
    chk("rst_disp_bank", int'(bus.disp_bank), 0);
    reset = 1'b1;
    #1;
    chk("clr_first_we", int'(bus.clr_we), 1);
    chk("clr_first_addr", int'(bus.clr_addr), 0);
    for (int i = 1; i < NCLR; i++) begin
      cycle();
      chk("clr_seq_bank", int'(bus.clr_bank), i / 4);
      chk("clr_seq_addr", int'(bus.clr_addr), i % 4);
    end
    cycle();
    chk("run_ready", int'(bus.wr_ready), 1);
    chk("run_clr_we", int'(bus.clr_we), 0);
  endtask

  initial begin
    drive(0, 0, 0, 0);
    do_reset_and_clear();

    pulse(1, 0, 0, 0);
    chk("alloc_first", int'(bus.wr_bank), 1);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    chk("swap_ack", int'(bus.disp_ack), 1);
    chk("swap_bank", int'(bus.disp_bank), 1);
    chk("swap_new", int'(bus.disp_new), 1);
    pulse(1, 0, 0, 0);
    chk("alloc_after_swap", int'(bus.wr_bank), 0);

    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    chk("alloc_third", int'(bus.wr_bank), 2);
    pulse(0, 1, 0, 0);
    chk("drop_one", int'(bus.drop_cnt), 1);
    pulse(0, 0, 0, 1);
    chk("newest_bank", int'(bus.disp_bank), 2);
    chk("newest_new", int'(bus.disp_new), 1);

    pulse(0, 0, 0, 1);
    chk("empty_ack", int'(bus.disp_ack), 1);
    chk("empty_new", int'(bus.disp_new), 0);
    chk("empty_bank", int'(bus.disp_bank), 2);

    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 1);
    chk("bypass_bank", int'(bus.disp_bank), 0);
    chk("bypass_new", int'(bus.disp_new), 1);
    chk("bypass_drop", int'(bus.drop_cnt), 1);
    pulse(0, 0, 0, 1);
    chk("bypass_rvld0", int'(bus.disp_new), 0);

    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    chk("pre_reset_busy", int'(bus.wr_busy), 1);
    do_reset_and_clear();
    chk("post_reset_bank", int'(bus.disp_bank), 0);

    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    chk("abort_alloc", int'(bus.wr_bank), 2);
    pulse(0, 0, 1, 0);
    chk("abort_free", int'(bus.wr_busy), 0);
    pulse(0, 0, 0, 1);
    chk("abort_keep_r", int'(bus.disp_bank), 1);
    chk("abort_keep_new", int'(bus.disp_new), 1);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      cycle();
    end
    reset = 1'b1;
    drive(0, 0, 0, 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
